// File: rtl/calc_e_best.sv
// calc_e_best: tracks the lowest-energy sequence of a search run and emits improvement events.
// Latency: 1 cycle from accepted candidate to updated best/count/event outputs.
// Backpressure: o_ready drops outside RUN, on i_start, and while an undrained improvement event blocks the slot.
//
// Ports:
//   clk, rst          - clock and synchronous active-low reset
//   i_start           - one-cycle pulse that clears the statistics and (re)starts a run
//   i_target, i_limit - stop energy and evaluation limit (0 = unlimited), latched on i_start
//   i_seq/i_e/i_valid - candidate stream from the energy stage, accepted when o_ready is high
//   o_imp_*           - one-deep improvement event, handshaken with i_imp_ready
//   o_best_*, o_count - running best sequence/energy and accepted-evaluation count
//   o_busy/o_done/o_hit - run status; o_hit means the run ended by reaching the target
module calc_e_best #(
    parameter int SEQ_WIDTH = 20,
    parameter int E_WIDTH   = 20,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [E_WIDTH-1:0]   i_target,
    input  logic [CNT_WIDTH-1:0] i_limit,
    input  logic [SEQ_WIDTH-1:0] i_seq,
    input  logic [E_WIDTH-1:0]   i_e,
    input  logic                 i_valid,
    output logic                 o_ready,
    output logic [SEQ_WIDTH-1:0] o_imp_seq,
    output logic [E_WIDTH-1:0]   o_imp_e,
    output logic                 o_imp_valid,
    input  logic                 i_imp_ready,
    output logic [SEQ_WIDTH-1:0] o_best_seq,
    output logic [E_WIDTH-1:0]   o_best_e,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_hit
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state;
    logic [E_WIDTH-1:0]   target_q;
    logic [CNT_WIDTH-1:0] limit_q;
    logic                 best_vld;
    logic [SEQ_WIDTH-1:0] best_seq;
    logic [E_WIDTH-1:0]   best_e;
    logic [CNT_WIDTH-1:0] count;
    logic                 imp_vld;
    logic [SEQ_WIDTH-1:0] imp_seq;
    logic [E_WIDTH-1:0]   imp_e;
    logic                 hit;

    logic                 slot_free;
    logic                 accept;
    logic                 improve;
    logic [E_WIDTH-1:0]   best_e_post;
    logic [CNT_WIDTH-1:0] count_inc;
    logic                 stop_target;
    logic                 stop_limit;

    // The event register is one deep: a new candidate may only be taken when
    // any improvement it produces has somewhere to go this cycle.
    assign slot_free = !imp_vld || i_imp_ready;
    assign o_ready   = (state == ST_RUN) && !i_start && slot_free;

    always_comb begin
        accept      = i_valid && o_ready;
        // Strict compare keeps the earlier sequence on an energy tie.
        improve     = accept && (!best_vld || (i_e < best_e));
        best_e_post = improve ? i_e : best_e;
        count_inc   = (&count) ? count : (count + CNT_WIDTH'(1));
        // Termination uses the post-update best and count; target has priority.
        stop_target = accept && (best_e_post <= target_q);
        stop_limit  = accept && (limit_q != '0) && (count_inc == limit_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ST_IDLE;
            target_q <= '0;
            limit_q  <= '0;
            best_vld <= 1'b0;
            best_seq <= '0;
            best_e   <= '1;
            count    <= '0;
            imp_vld  <= 1'b0;
            imp_seq  <= '0;
            imp_e    <= '0;
            hit      <= 1'b0;
        end else begin
            // Event slot: a fresh improvement overrides the drain of the old one.
            if (improve) begin
                imp_vld <= 1'b1;
                imp_seq <= i_seq;
                imp_e   <= i_e;
            end else if (imp_vld && i_imp_ready) begin
                imp_vld <= 1'b0;
            end

            // i_start never coincides with an accept because it masks o_ready,
            // and it leaves a pending event alone so the host still sees it.
            if (i_start) begin
                state    <= ST_RUN;
                target_q <= i_target;
                limit_q  <= i_limit;
                best_vld <= 1'b0;
                best_seq <= '0;
                best_e   <= '1;
                count    <= '0;
                hit      <= 1'b0;
            end else if (accept) begin
                count <= count_inc;
                if (improve) begin
                    best_vld <= 1'b1;
                    best_seq <= i_seq;
                    best_e   <= i_e;
                end
                if (stop_target) begin
                    state <= ST_DONE;
                    hit   <= 1'b1;
                end else if (stop_limit) begin
                    state <= ST_DONE;
                    hit   <= 1'b0;
                end
            end
        end
    end

    assign o_imp_valid = imp_vld;
    assign o_imp_seq   = imp_seq;
    assign o_imp_e     = imp_e;
    assign o_best_seq  = best_seq;
    assign o_best_e    = best_e;
    assign o_count     = count;
    assign o_busy      = (state == ST_RUN);
    assign o_done      = (state == ST_DONE);
    assign o_hit       = hit;

endmodule
